regfile_wb_arbiter: RTL and testbench

Shares the single write port of the RV64I register file between several writeback requesters, such as the ALU, the load unit and the CSR unit. It uses round-robin arbitration with a valid/ready handshake and a registered write port toward the register file. It also keeps a 32-entry pending-write scoreboard so decode can detect RAW hazards on rs1/rs2. It sits between the execute/memory units and the register file, and drives its write_en, rd_addr and rd_data inputs.

---
 rtl/rv64i_regfile_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 64 ++++++
 rtl/regfile_wb_arbiter.sv | 166 ++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv64i_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv64i_regfile_pkg
// Description : Shared constants for the RV64I register file and its
//               writeback path.
// Revision    : 1.0 - initial release
// ============================================================================
package rv64i_regfile_pkg;

  localparam int              XLEN     = 64;
  localparam int              ADDR_W   = 5;
  localparam int              NUM_REGS = 32;
  localparam logic [4:0]      X0_ADDR  = 5'd0;

endpackage : rv64i_regfile_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Generic N-way round-robin arbiter. The grant is combinational
//               from the request vector; the priority pointer is updated to
//               the granted index on cycles that grant and holds otherwise.
//               After reset the pointer is N-1, so index 0 has first priority.
// Ports       : clk         - clock
//               rst         - asynchronous active-high reset
//               req_i       - request vector
//               gnt_o       - one-hot grant (subset of req_i)
//               gnt_valid_o - any grant this cycle
//               gnt_idx_o   - binary index of the granted request
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic             gnt_valid_o,
  output logic [IDX_W-1:0] gnt_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;
  logic [IDX_W-1:0] w_cand;

  // Scan from ptr+1 around to ptr; the first active request wins.
  always_comb begin
    gnt_o       = '0;
    gnt_valid_o = 1'b0;
    gnt_idx_o   = ptr_q;
    w_cand      = '0;
    for (int off = 1; off <= N; off++) begin
      w_cand = IDX_W'((int'(ptr_q) + off) % N);
      if (!gnt_valid_o && req_i[w_cand]) begin
        gnt_valid_o   = 1'b1;
        gnt_idx_o     = w_cand;
        gnt_o[w_cand] = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (gnt_valid_o) begin
      ptr_d = gnt_idx_o;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= IDX_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Shares the single register-file write port among NUM_REQ
//               writeback requesters (round-robin, valid/ready), drives a
//               registered write port, and keeps a pending-write scoreboard
//               for RAW hazard detection in decode.
// Ports       : clk, rst                    - clock, async active-high reset
//               req_valid/req_ready         - per-requester handshake
//               req_rd_addr/req_rd_data     - packed per-requester addr/data
//               write_en/rd_addr/rd_data    - registered regfile write port
//               reserve_en/reserve_addr     - decode reserves a destination
//               flush                       - clear all busy bits
//               rs1_addr/rs2_addr           - decode source registers
//               rs1_busy/rs2_busy           - source has a pending write
//               conflict_count              - (WB_ARB_PERF_EN only) cycles
//                                             with >=2 requests, saturating
// Options     : define WB_ARB_PERF_EN to add the conflict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int XLEN    = 64,
  parameter int ADDR_W  = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd_addr,
  input  logic [NUM_REQ*XLEN-1:0] req_rd_data,
  output logic                    write_en,
  output logic [ADDR_W-1:0]       rd_addr,
  output logic [XLEN-1:0]         rd_data,
  input  logic                    reserve_en,
  input  logic [ADDR_W-1:0]       reserve_addr,
  input  logic                    flush,
  input  logic [ADDR_W-1:0]       rs1_addr,
  input  logic [ADDR_W-1:0]       rs2_addr,
`ifdef WB_ARB_PERF_EN
  output logic [31:0]             conflict_count,
`endif
  output logic                    rs1_busy,
  output logic                    rs2_busy
);

  import rv64i_regfile_pkg::*;

  localparam int                IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int                NREGS  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(X0_ADDR);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic             w_gnt_valid;
  logic [IDX_W-1:0] w_gnt_idx;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_valid),
    .gnt_o       (req_ready),
    .gnt_valid_o (w_gnt_valid),
    .gnt_idx_o   (w_gnt_idx)
  );

  // --------------------------------------------------------------------------
  // Registered write port
  // --------------------------------------------------------------------------
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic [XLEN-1:0]   rd_data_q,  rd_data_d;

  // Address/data only load on a grant so they hold between writes.
  always_comb begin
    write_en_d = w_gnt_valid;
    rd_addr_d  = rd_addr_q;
    rd_data_d  = rd_data_q;
    if (w_gnt_valid) begin
      rd_addr_d = req_rd_addr[w_gnt_idx*ADDR_W +: ADDR_W];
      rd_data_d = req_rd_data[w_gnt_idx*XLEN +: XLEN];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_en_q <= 1'b0;
      rd_addr_q  <= '0;
      rd_data_q  <= '0;
    end else begin
      write_en_q <= write_en_d;
      rd_addr_q  <= rd_addr_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign write_en = write_en_q;
  assign rd_addr  = rd_addr_q;
  assign rd_data  = rd_data_q;

  // --------------------------------------------------------------------------
  // Pending-write scoreboard
  // --------------------------------------------------------------------------
  logic [NREGS-1:0] busy_q, busy_d;

  // Clear is applied before set so a same-cycle reserve of the address being
  // retired keeps the bit. x0 is forced clear because it is never written.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (write_en_q) begin
        busy_d[rd_addr_q] = 1'b0;
      end
      if (reserve_en) begin
        busy_d[reserve_addr] = 1'b1;
      end
      busy_d[ZERO_A] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = (rs1_addr != ZERO_A) && busy_q[rs1_addr];
  assign rs2_busy = (rs2_addr != ZERO_A) && busy_q[rs2_addr];

  // --------------------------------------------------------------------------
  // Optional contention counter
  // --------------------------------------------------------------------------
`ifdef WB_ARB_PERF_EN
  logic [31:0] conflict_q, conflict_d;
  logic        w_multi_req;

  // Clearing the lowest set bit leaves something only if two or more are set.
  assign w_multi_req = |(req_valid & (req_valid - NUM_REQ'(1)));

  always_comb begin
    conflict_d = conflict_q;
    if (w_multi_req && (conflict_q != 32'hFFFF_FFFF)) begin
      conflict_d = conflict_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_q <= '0;
    end else begin
      conflict_q <= conflict_d;
    end
  end

  assign conflict_count = conflict_q;
`endif

endmodule : regfile_wb_arbiter
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed self-checking bench for regfile_wb_arbiter
//               (NUM_REQ=3, XLEN=64, ADDR_W=5). Honors WB_ARB_PERF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

  localparam int NR = 3;
  localparam int XL = 64;
  localparam int AW = 5;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_rd_addr;
  logic [NR*XL-1:0]  req_rd_data;
  logic              write_en;
  logic [AW-1:0]     rd_addr;
  logic [XL-1:0]     rd_data;
  logic              reserve_en;
  logic [AW-1:0]     reserve_addr;
  logic              flush;
  logic [AW-1:0]     rs1_addr;
  logic [AW-1:0]     rs2_addr;
  logic              rs1_busy;
  logic              rs2_busy;
`ifdef WB_ARB_PERF_EN
  logic [31:0]       conflict_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  regfile_wb_arbiter #(
    .NUM_REQ (NR),
    .XLEN    (XL),
    .ADDR_W  (AW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rd_addr  (req_rd_addr),
    .req_rd_data  (req_rd_data),
    .write_en     (write_en),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .reserve_en   (reserve_en),
    .reserve_addr (reserve_addr),
    .flush        (flush),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
`ifdef WB_ARB_PERF_EN
    .conflict_count (conflict_count),
`endif
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A requester that was valid but not granted must still be valid next edge.
  logic [NR-1:0] pend_q = '0;
  always @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      n_checks <= n_checks + 1;
      if ((pend_q & ~req_valid) != '0) begin
        $display("FAIL valid_hold: valid=%b pending_before=%b", req_valid, pend_q);
        n_fail <= n_fail + 1;
      end
      pend_q <= req_valid & ~req_ready;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [XL-1:0] d);
    req_rd_addr[i*AW +: AW] = a;
    req_rd_data[i*XL +: XL] = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0; req_rd_addr = '0; req_rd_data = '0;
    reserve_en = 1'b0; reserve_addr = '0; flush = 1'b0;
    rs1_addr = '0; rs2_addr = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (write_en !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 64'd0) begin
      $display("FAIL reset_port: we=%b addr=%0d data=%h want 0/0/0", write_en, rd_addr, rd_data);
      n_fail++;
    end
    // Write in flight on addr 5 from requester 1, then async reset mid-cycle.
    req_valid = 3'b010; set_req(1, 5'd5, 64'h55); reserve_en = 1'b1; reserve_addr = 5'd5;
    rs1_addr = 5'd5;
    #1;
    n_checks++;
    if (req_ready !== 3'b010) begin
      $display("FAIL reset_grant1: ready=%b want 010", req_ready);
      n_fail++;
    end
    tick();
    req_valid = '0; reserve_en = 1'b0;
    #1;
    n_checks++;
    if (write_en !== 1'b1 || rd_addr !== 5'd5 || rs1_busy !== 1'b1) begin
      $display("FAIL reset_prewrite: we=%b addr=%0d busy=%b want 1/5/1", write_en, rd_addr, rs1_busy);
      n_fail++;
    end
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (write_en !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 64'd0 || rs1_busy !== 1'b0) begin
      $display("FAIL reset_midwrite: we=%b addr=%0d data=%h busy=%b want 0/0/0/0",
               write_en, rd_addr, rd_data, rs1_busy);
      n_fail++;
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] mask [8];
    for (int k = 0; k < 8; k++) mask[k] = 3'b111;
    mask[6] = 3'b011;
    mask[7] = 3'b010;
    for (int i = 0; i < NR; i++) set_req(i, AW'(10 + i), 64'h1000 + 64'(i));
    for (int k = 0; k < 8; k++) begin
      req_valid = mask[k];
      #1;
      n_checks++;
      if (req_ready !== NR'(1 << (k % 3))) begin
        $display("FAIL rr_grant%0d: ready=%b want %b", k, req_ready, NR'(1 << (k % 3)));
        n_fail++;
      end
      tick();
      n_checks++;
      if (write_en !== 1'b1 || rd_addr !== AW'(10 + k % 3) || rd_data !== 64'h1000 + 64'(k % 3)) begin
        $display("FAIL rr_write%0d: we=%b addr=%0d data=%h want 1/%0d/%h",
                 k, write_en, rd_addr, rd_data, 10 + k % 3, 64'h1000 + 64'(k % 3));
        n_fail++;
      end
    end
    req_valid = '0;
    tick();
    n_checks++;
    if (write_en !== 1'b0 || rd_addr !== 5'd11 || rd_data !== 64'h1001) begin
      $display("FAIL rr_idle_hold: we=%b addr=%0d data=%h want 0/11/1001", write_en, rd_addr, rd_data);
      n_fail++;
    end
  endtask

  task automatic test_raw_scoreboard();
    reserve_en = 1'b1; reserve_addr = 5'd7; rs1_addr = 5'd7; rs2_addr = 5'd8;
    #1;
    n_checks++;
    if (rs1_busy !== 1'b0) begin
      $display("FAIL raw_c0: rs1_busy=%b want 0", rs1_busy);
      n_fail++;
    end
    tick();
    reserve_en = 1'b0;
    for (int c = 1; c <= 2; c++) begin
      n_checks++;
      if (rs1_busy !== 1'b1 || rs2_busy !== 1'b0) begin
        $display("FAIL raw_c%0d: rs1_busy=%b rs2_busy=%b want 1/0", c, rs1_busy, rs2_busy);
        n_fail++;
      end
      tick();
    end
    req_valid = 3'b010; set_req(1, 5'd7, 64'hDEAD_BEEF);
    #1;
    n_checks++;
    if (rs1_busy !== 1'b1 || req_ready !== 3'b010) begin
      $display("FAIL raw_c3: rs1_busy=%b ready=%b want 1/010", rs1_busy, req_ready);
      n_fail++;
    end
    tick();
    req_valid = '0;
    n_checks++;
    if (write_en !== 1'b1 || rd_addr !== 5'd7 || rd_data !== 64'hDEAD_BEEF || rs1_busy !== 1'b1) begin
      $display("FAIL raw_c4: we=%b addr=%0d data=%h busy=%b want 1/7/deadbeef/1",
               write_en, rd_addr, rd_data, rs1_busy);
      n_fail++;
    end
    tick();
    n_checks++;
    if (rs1_busy !== 1'b0 || write_en !== 1'b0) begin
      $display("FAIL raw_c5: rs1_busy=%b we=%b want 0/0", rs1_busy, write_en);
      n_fail++;
    end
  endtask

  task automatic test_reserve_clear_same_cycle();
    reserve_en = 1'b1; reserve_addr = 5'd9; rs1_addr = 5'd9;
    tick();
    reserve_en = 1'b0; req_valid = 3'b001; set_req(0, 5'd9, 64'h99);
    #1;
    n_checks++;
    if (req_ready !== 3'b001 || rs1_busy !== 1'b1) begin
      $display("FAIL same_grant: ready=%b busy=%b want 001/1", req_ready, rs1_busy);
      n_fail++;
    end
    tick();
    req_valid = '0; reserve_en = 1'b1; reserve_addr = 5'd9;
    n_checks++;
    if (write_en !== 1'b1 || rd_addr !== 5'd9) begin
      $display("FAIL same_write: we=%b addr=%0d want 1/9", write_en, rd_addr);
      n_fail++;
    end
    tick();
    reserve_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      n_checks++;
      if (rs1_busy !== 1'b1) begin
        $display("FAIL same_keep%0d: rs1_busy=%b want 1", c, rs1_busy);
        n_fail++;
      end
      tick();
    end
  endtask

  task automatic test_flush();
    reserve_en = 1'b1; reserve_addr = 5'd12;
    req_valid = 3'b001; set_req(0, 5'd3, 64'h33);
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      $display("FAIL flush_grant: ready=%b want 001", req_ready);
      n_fail++;
    end
    tick();
    req_valid = '0; reserve_addr = 5'd13; flush = 1'b1; rs1_addr = 5'd9; rs2_addr = 5'd12;
    #1;
    n_checks++;
    if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1 || write_en !== 1'b1 || rd_addr !== 5'd3 || rd_data !== 64'h33) begin
      $display("FAIL flush_pre: b1=%b b2=%b we=%b addr=%0d data=%h want 1/1/1/3/33",
               rs1_busy, rs2_busy, write_en, rd_addr, rd_data);
      n_fail++;
    end
    tick();
    flush = 1'b0; reserve_en = 1'b0; rs1_addr = 5'd13; rs2_addr = 5'd9;
    #1;
    n_checks++;
    if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      $display("FAIL flush_post_a: b13=%b b9=%b want 0/0", rs1_busy, rs2_busy);
      n_fail++;
    end
    rs2_addr = 5'd12;
    #1;
    n_checks++;
    if (rs2_busy !== 1'b0) begin
      $display("FAIL flush_post_b: b12=%b want 0", rs2_busy);
      n_fail++;
    end
  endtask

  task automatic test_x0();
    tick();
    reserve_en = 1'b1; reserve_addr = 5'd0; rs1_addr = 5'd0;
    req_valid = 3'b100; set_req(2, 5'd0, 64'h77);
    #1;
    n_checks++;
    if (rs1_busy !== 1'b0 || req_ready !== 3'b100) begin
      $display("FAIL x0_c0: busy=%b ready=%b want 0/100", rs1_busy, req_ready);
      n_fail++;
    end
    tick();
    reserve_en = 1'b0; req_valid = '0;
    n_checks++;
    if (write_en !== 1'b1 || rd_addr !== 5'd0 || rd_data !== 64'h77 || rs1_busy !== 1'b0) begin
      $display("FAIL x0_c1: we=%b addr=%0d data=%h busy=%b want 1/0/77/0",
               write_en, rd_addr, rd_data, rs1_busy);
      n_fail++;
    end
    tick();
    n_checks++;
    if (rs1_busy !== 1'b0) begin
      $display("FAIL x0_c2: busy=%b want 0", rs1_busy);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    // Pointer is at 2 (last grant was requester 2).
    req_valid = 3'b101; set_req(0, 5'd20, 64'hA0); set_req(2, 5'd22, 64'hA2);
    #1;
    n_checks++;
    if (req_ready !== 3'b001) begin
      $display("FAIL b2b_g0: ready=%b want 001", req_ready);
      n_fail++;
    end
    tick();
    req_valid = 3'b100;
    #1;
    n_checks++;
    if (req_ready !== 3'b100 || write_en !== 1'b1 || rd_addr !== 5'd20) begin
      $display("FAIL b2b_g1: ready=%b we=%b addr=%0d want 100/1/20", req_ready, write_en, rd_addr);
      n_fail++;
    end
    tick();
    req_valid = '0;
    n_checks++;
    if (write_en !== 1'b1 || rd_addr !== 5'd22 || rd_data !== 64'hA2) begin
      $display("FAIL b2b_w1: we=%b addr=%0d data=%h want 1/22/a2", write_en, rd_addr, rd_data);
      n_fail++;
    end
    tick();
    tick();
    // Pointer held at 2 through the idle cycles: requester 0 first again.
    req_valid = 3'b011; set_req(0, 5'd1, 64'hB0); set_req(1, 5'd2, 64'hB1);
    #1;
    n_checks++;
    if (req_ready !== 3'b001 || write_en !== 1'b0) begin
      $display("FAIL b2b_g2: ready=%b we=%b want 001/0", req_ready, write_en);
      n_fail++;
    end
    tick();
    req_valid = 3'b010;
    #1;
    n_checks++;
    if (req_ready !== 3'b010 || rd_addr !== 5'd1) begin
      $display("FAIL b2b_g3: ready=%b addr=%0d want 010/1", req_ready, rd_addr);
      n_fail++;
    end
    tick();
    req_valid = '0;
    n_checks++;
    if (write_en !== 1'b1 || rd_addr !== 5'd2 || rd_data !== 64'hB1) begin
      $display("FAIL b2b_w3: we=%b addr=%0d data=%h want 1/2/b1", write_en, rd_addr, rd_data);
      n_fail++;
    end
    tick();
  endtask

`ifdef WB_ARB_PERF_EN
  task automatic test_perf_counter();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (conflict_count !== 32'd0) begin
      $display("FAIL perf_reset: count=%0d want 0", conflict_count);
      n_fail++;
    end
    req_valid = 3'b101;
    for (int k = 0; k < 10; k++) tick();
    req_valid = 3'b001;
    for (int k = 0; k < 5; k++) tick();
    req_valid = '0;
    tick();
    n_checks++;
    if (conflict_count !== 32'd10) begin
      $display("FAIL perf_count: count=%0d want 10", conflict_count);
      n_fail++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_raw_scoreboard();
    test_reserve_clear_same_cycle();
    test_flush();
    test_x0();
    test_back_to_back();
`ifdef WB_ARB_PERF_EN
    test_perf_counter();
`endif
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_wb_arbiter
`default_nettype wire
